reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement queue for the out-of-order core; sits beside the register alias table (RAT).
//  Issues a ROB tag per renamed instruction (RAT tag_in), captures results from writeback, and retires up to two
//  completed entries per cycle in program order. Commit ports drive the RAT free/free2 and tag_done/tag_done2 inputs.
//  Tag-indexed operand read ports let dispatch fetch values of still-allocated producers.
// PARAMETERS
//  DEPTH   16  number of entries; power of two, 2..32
//  TAG_W   5   tag width; DEPTH <= 2**TAG_W; tag = entry index
//  DATA_W  32  result width
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  flush          in   1       synchronous squash of all entries
//  alloc_req      in   1       allocate one entry this cycle
//  alloc_dest     in   5       architectural destination register
//  alloc_ready    out  1       entry available (= ~full)
//  alloc_tag      out  TAG_W   tag granted when alloc_req & alloc_ready (= tail index)
//  wb_valid       in   1       result writeback strobe
//  wb_tag         in   TAG_W   entry being completed
//  wb_data        in   DATA_W  result value
//  rd_tag_a/b     in   TAG_W   operand lookup tags
//  rd_ready_a/b   out  1       entry done (or completing this cycle)
//  rd_data_a/b    out  DATA_W  entry value
//  cm0_valid      out  1       head entry retires this cycle
//  cm0_tag        out  TAG_W   retiring tag (to RAT tag_done)
//  cm0_dest       out  5       architectural destination
//  cm0_data       out  DATA_W  value for register file
//  cm1_valid/tag/dest/data  out  same as cm0 for head+1
//  count          out  TAG_W+1 occupied entries
//  empty, full    out  1       count==0 / count==DEPTH
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all valid/done cleared; alloc_ready=1, empty=1, full=0, cm*_valid=0, alloc_tag=0.
//  - Entry state: valid, done, dest, data. Tags wrap modulo DEPTH; no separate wrap bit; count disambiguates.
//  - Allocate: on edge with alloc_req & ~full: entry[tail] <= {valid=1, done=0, dest}; tail<=tail+1.
//    alloc_req while full is ignored (no state change). full uses registered count: a same-cycle commit does
//    NOT make room for a same-cycle alloc.
//  - Writeback: on edge with wb_valid & entry[wb_tag].valid: done<=1, data<=wb_data. wb to an invalid entry,
//    or to an already-done entry, is ignored (no overwrite).
//  - Commit (combinational from registered state, takes effect at next edge):
//    cm0_valid = valid[head] & done[head]; cm1_valid = cm0_valid & valid[head+1] & done[head+1].
//    On the edge: retired entries cleared, head += cm0_valid+cm1_valid. Commit is unconditional (no stall input).
//  - Latency: wb at edge N -> earliest cm*_valid in cycle after N. Alloc at edge N -> earliest wb at edge N+1.
//  - count next = count + (alloc accepted) - cm0_valid - cm1_valid; simultaneous alloc+commit handled in one edge.
//  - Operand read: combinational; rd_ready = valid & done, or wb_valid & wb_tag==rd_tag & valid (bypass wb_data).
//    Invalid entry -> rd_ready=0, rd_data=0.
//  - Flush: synchronous, highest priority: clears all valid/done, head=tail=count=0; alloc/wb/commit that cycle
//    are discarded, but cm*_valid outputs in that cycle are still driven from state (the consumer must gate with flush).
//  - Reset mid-operation: asynchronous return to reset state; no partial commit.
// TESTING
//  1 Reset, alloc 3 (dest 4,5,6) -> alloc_tag 0,1,2; count=3; cm0_valid=0 until wb.
//  2 wb tag1 then tag0 (data 0xA,0xB) -> cycle after tag0 wb: cm0={0,d4,0xB}, cm1={1,d5,0xA}; count 3->1.
//  3 Fill 16 entries -> full=1, alloc_ready=0; 17th alloc_req ignored; complete head, retire -> alloc_tag=0 (wrap).
//  4 wb tag2 data 0x55 with rd_tag_a=2 same cycle -> rd_ready_a=1, rd_data_a=0x55; wb to an unallocated tag -> no effect.
//  5 Full ROB, head done, alloc_req same cycle -> commit occurs, alloc rejected; next cycle alloc accepted.
//  6 Flush with 5 entries pending, 2 done -> next cycle empty=1, count=0, no commits; assert rst mid-stream -> reset state.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement queue for the out-of-order core. Hands out a ROB tag
//   (the tail index) per renamed instruction, captures writeback results, and
//   retires up to two completed entries per cycle in program order. Two
//   tag-indexed read ports let dispatch pick up values of live producers,
//   including a same-cycle bypass of the writeback bus.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   flush                    synchronous squash of every entry (highest priority)
//   alloc_req / alloc_dest   allocate one entry for architectural reg alloc_dest
//   alloc_ready / alloc_tag  room available (~full) / tag granted (tail index)
//   wb_valid/wb_tag/wb_data  result writeback
//   rd_tag_a/b               operand lookup tags
//   rd_ready_a/b, rd_data_a/b  lookup result (done, or completing this cycle)
//   cm0_* / cm1_*            retirement of head and head+1 (valid, tag, dest, data)
//   count, empty, full       occupancy
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_req,
    input  logic [4:0]        alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [TAG_W-1:0]  rd_tag_a,
    input  logic [TAG_W-1:0]  rd_tag_b,
    output logic              rd_ready_a,
    output logic              rd_ready_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              cm0_valid,
    output logic [TAG_W-1:0]  cm0_tag,
    output logic [4:0]        cm0_dest,
    output logic [DATA_W-1:0] cm0_data,
    output logic              cm1_valid,
    output logic [TAG_W-1:0]  cm1_tag,
    output logic [4:0]        cm1_dest,
    output logic [DATA_W-1:0] cm1_data,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              full
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
    logic [4:0]        dest_q [DEPTH];
    logic [4:0]        dest_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [IDX_W-1:0]  head1, wb_idx;
    logic              wb_in_range, wb_hit, alloc_fire, cm0_fire, cm1_fire;
    logic [DEPTH-1:0]  alloc_sel, wb_sel, retire_sel;

    assign head1       = head_q + IDX_W'(1);
    assign wb_idx      = wb_tag[IDX_W-1:0];
    // Tags beyond DEPTH never name an entry and must not alias onto one.
    assign wb_in_range = ({1'b0, wb_tag} < DEPTH_C);

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign alloc_ready = ~full;
    assign alloc_tag   = TAG_W'(tail_q);
    assign count       = count_q;

    // Room is judged on registered occupancy only, so a retirement this
    // cycle never frees a slot for an allocation in the same cycle.
    assign alloc_fire = alloc_req & ~full;
    assign cm0_fire   = valid_q[head_q] & done_q[head_q];
    assign cm1_fire   = cm0_fire & valid_q[head1] & done_q[head1];
    // A second writeback to an already-completed entry is dropped.
    assign wb_hit     = wb_valid & wb_in_range & valid_q[wb_idx] & ~done_q[wb_idx];

    // Per-entry one-hot update strobes. Allocation targets an invalid slot,
    // writeback a valid not-done slot, retirement a done slot, so at most one
    // of the three can select a given entry in a cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_sel
        assign alloc_sel[gi]  = alloc_fire & (tail_q == IDX_W'(gi));
        assign wb_sel[gi]     = wb_hit & (wb_idx == IDX_W'(gi));
        assign retire_sel[gi] = (cm0_fire & (head_q == IDX_W'(gi)))
                              | (cm1_fire & (head1 == IDX_W'(gi)));
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        dest_d  = dest_q;
        data_d  = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (retire_sel[i]) begin
                valid_d[i] = 1'b0;
                done_d[i]  = 1'b0;
            end
            if (alloc_sel[i]) begin
                valid_d[i] = 1'b1;
                done_d[i]  = 1'b0;
                dest_d[i]  = alloc_dest;
            end
            if (wb_sel[i]) begin
                done_d[i] = 1'b1;
                data_d[i] = wb_data;
            end
        end
        // Payload writes during a flush are harmless: the entry is invalid.
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
        end
    end

    always_comb begin
        head_d  = head_q + IDX_W'(cm0_fire) + IDX_W'(cm1_fire);
        tail_d  = tail_q + IDX_W'(alloc_fire);
        count_d = count_q + (TAG_W+1)'(alloc_fire)
                          - (TAG_W+1)'(cm0_fire) - (TAG_W+1)'(cm1_fire);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload storage needs no reset: it is only observed through valid/done.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end

    // Commit ports, driven from registered state even during a flush.
    assign cm0_valid = cm0_fire;
    assign cm0_tag   = TAG_W'(head_q);
    assign cm0_dest  = cm0_fire ? dest_q[head_q] : '0;
    assign cm0_data  = cm0_fire ? data_q[head_q] : '0;
    assign cm1_valid = cm1_fire;
    assign cm1_tag   = TAG_W'(head1);
    assign cm1_dest  = cm1_fire ? dest_q[head1] : '0;
    assign cm1_data  = cm1_fire ? data_q[head1] : '0;

    // Operand read ports: stored value if done, else bypass the writeback bus.
    logic [1:0][TAG_W-1:0]  rd_tag_v;
    logic [1:0]             rd_ready_v;
    logic [1:0][DATA_W-1:0] rd_data_v;

    assign rd_tag_v[0] = rd_tag_a;
    assign rd_tag_v[1] = rd_tag_b;

    for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
        logic [IDX_W-1:0] idx;
        logic             live, bypass;
        assign idx    = rd_tag_v[gi][IDX_W-1:0];
        assign live   = ({1'b0, rd_tag_v[gi]} < DEPTH_C) & valid_q[idx];
        assign bypass = wb_valid & (wb_tag == rd_tag_v[gi]);
        assign rd_ready_v[gi] = live & (done_q[idx] | bypass);
        assign rd_data_v[gi]  = !live       ? '0 :
                                done_q[idx] ? data_q[idx] :
                                bypass      ? wb_data : '0;
    end

    assign rd_ready_a = rd_ready_v[0];
    assign rd_ready_b = rd_ready_v[1];
    assign rd_data_a  = rd_data_v[0];
    assign rd_data_b  = rd_data_v[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH=16, TAG_W=5, DATA_W=32).
// Allocations push the expected retirement {tag, dest, data} into a queue;
// a negedge monitor pops and compares whenever the DUT retires an entry.
module tb_reorder_buffer;

    logic        clk, rst, flush, alloc_req, wb_valid;
    logic [4:0]  alloc_dest, alloc_tag, wb_tag, rd_tag_a, rd_tag_b;
    logic [4:0]  cm0_tag, cm0_dest, cm1_tag, cm1_dest;
    logic [31:0] wb_data, rd_data_a, rd_data_b, cm0_data, cm1_data;
    logic        alloc_ready, rd_ready_a, rd_ready_b, cm0_valid, cm1_valid;
    logic        empty, full;
    logic [5:0]  count;

    reorder_buffer #(.DEPTH(16), .TAG_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_req(alloc_req), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
        .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .cm0_valid(cm0_valid), .cm0_tag(cm0_tag), .cm0_dest(cm0_dest), .cm0_data(cm0_data),
        .cm1_valid(cm1_valid), .cm1_tag(cm1_tag), .cm1_dest(cm1_dest), .cm1_data(cm1_data),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct packed {
        logic [4:0]  tag;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [4:0]  tb_tail = '0;
    logic [31:0] wbdata [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_commit(input string port, input logic [4:0] tag,
                                input logic [4:0] dest, input logic [31:0] data);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_unexpected: got commit tag 0x%0h, expected no commit at %0t", port, tag, $time);
        end else begin
            e = sbq.pop_front();
            chk({port, "_tag"}, 64'(tag), 64'(e.tag));
            chk({port, "_dest"}, 64'(dest), 64'(e.dest));
            chk({port, "_data"}, 64'(data), 64'(e.data));
            $display("commit %s tag=%0d dest=%0d data=0x%0h", port, tag, dest, data);
        end
    endtask

    // Monitor: retirements during a flush cycle are gated off by the consumer.
    always @(negedge clk) begin
        if (rst && !flush) begin
            if (cm1_valid) chk("cm1_needs_cm0", 64'(cm0_valid), 64'd1);
            if (cm0_valid) check_commit("cm0", cm0_tag, cm0_dest, cm0_data);
            if (cm1_valid) check_commit("cm1", cm1_tag, cm1_dest, cm1_data);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_alloc(input logic [4:0] d, input logic [31:0] exp_data);
        alloc_req  = 1'b1;
        alloc_dest = d;
        @(negedge clk);
        chk("alloc_ready", 64'(alloc_ready), 64'd1);
        chk("alloc_tag", 64'(alloc_tag), 64'(tb_tail));
        sbq.push_back('{tag: tb_tail, dest: d, data: exp_data});
        $display("alloc tag=%0d dest=%0d", tb_tail, d);
        tb_tail = tb_tail + 5'd1;
        if (tb_tail == 5'd16) tb_tail = '0;
        @(posedge clk);
        #1;
        alloc_req = 1'b0;
    endtask

    task automatic wb(input logic [4:0] t, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_tag   = t;
        wb_data  = d;
        $display("wb tag=%0d data=0x%0h", t, d);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] t;
        rst = 1'b0; flush = 1'b0; alloc_req = 1'b0; alloc_dest = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0; rd_tag_a = '0; rd_tag_b = '0;

        // Reset state
        #3;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_cm0_valid", 64'(cm0_valid), 64'd0);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // 1: three allocations, nothing retires before writeback
        do_alloc(5'd4, 32'hB);
        do_alloc(5'd5, 32'hA);
        do_alloc(5'd6, 32'h55);
        @(negedge clk);
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_cm0_idle", 64'(cm0_valid), 64'd0);

        // 2: out-of-order completion, dual retirement
        wb(5'd1, 32'hA);
        wb(5'd0, 32'hB);
        @(negedge clk);
        chk("t2_cm0_valid", 64'(cm0_valid), 64'd1);
        chk("t2_cm1_valid", 64'(cm1_valid), 64'd1);
        chk("t2_count_before", 64'(count), 64'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_count_after", 64'(count), 64'd1);
        chk("t2_cm0_after", 64'(cm0_valid), 64'd0);

        // 4: operand reads, writeback bypass, stray writeback
        rd_tag_a = 5'd2; rd_tag_b = 5'd3;
        #1;
        chk("t4_rd_pending", 64'(rd_ready_a), 64'd0);
        wb_valid = 1'b1; wb_tag = 5'd2; wb_data = 32'h55;
        #1;
        chk("t4_bypass_ready", 64'(rd_ready_a), 64'd1);
        chk("t4_bypass_data", 64'(rd_data_a), 64'h55);
        chk("t4_unalloc_ready", 64'(rd_ready_b), 64'd0);
        chk("t4_unalloc_data", 64'(rd_data_b), 64'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        #1;
        chk("t4_stored_ready", 64'(rd_ready_a), 64'd1);
        chk("t4_stored_data", 64'(rd_data_a), 64'h55);
        @(posedge clk); #1;
        chk("t4_retired_ready", 64'(rd_ready_a), 64'd0);
        chk("t4_empty", 64'(empty), 64'd1);
        wb_valid = 1'b1; wb_tag = 5'd7; wb_data = 32'h77; rd_tag_a = 5'd7;
        #1;
        chk("t4_stray_rd", 64'(rd_ready_a), 64'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        #1;
        chk("t4_stray_rd_after", 64'(rd_ready_a), 64'd0);
        chk("t4_stray_count", 64'(count), 64'd0);
        chk("t4_stray_cm0", 64'(cm0_valid), 64'd0);

        // 3: fill all 16 entries (tags 3..15, 0..2 -- tail wraps)
        for (int i = 0; i < 16; i++) begin
            wbdata[tb_tail] = 32'h100 + 32'(i);
            do_alloc(5'(i), 32'h100 + 32'(i));
        end
        #1;
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("t3_count", 64'(count), 64'd16);
        chk("t3_empty", 64'(empty), 64'd0);

        // 5: full with head done: commit happens, same-cycle alloc rejected
        wb(5'd3, wbdata[3]);
        alloc_req = 1'b1; alloc_dest = 5'd9;
        #1;
        chk("t5_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("t5_cm0_valid", 64'(cm0_valid), 64'd1);
        chk("t5_cm1_valid", 64'(cm1_valid), 64'd0);
        @(posedge clk); #1;
        chk("t5_count_rejected", 64'(count), 64'd15);
        wbdata[tb_tail] = 32'h200;
        do_alloc(5'd9, 32'h200);
        #1;
        chk("t5_count_refill", 64'(count), 64'd16);
        chk("t5_full_again", 64'(full), 64'd1);

        // Duplicate writeback is ignored; read port returns first value
        wb(5'd6, wbdata[6]);
        wb_valid = 1'b1; wb_tag = 5'd6; wb_data = 32'hDEAD; rd_tag_a = 5'd6;
        #1;
        chk("dup_rd_ready", 64'(rd_ready_a), 64'd1);
        chk("dup_rd_data", 64'(rd_data_a), 64'(wbdata[6]));
        @(posedge clk); #1;
        wb_valid = 1'b0;

        // Drain in program order
        for (int k = 0; k < 16; k++) begin
            t = 5'((4 + k) % 16);
            if (t != 5'd6) wb(t, wbdata[t]);
        end
        idle(3);
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_queue", 64'(sbq.size()), 64'd0);

        // 6: flush with 5 pending (tags 4..8), two of them done but not at head
        for (int i = 0; i < 5; i++) do_alloc(5'(10 + i), 32'h300 + 32'(i));
        wb(5'd6, 32'h302);
        wb(5'd8, 32'h304);
        #1;
        chk("t6_count", 64'(count), 64'd5);
        chk("t6_no_commit", 64'(cm0_valid), 64'd0);
        flush = 1'b1; alloc_req = 1'b1; alloc_dest = 5'd1;
        wb_valid = 1'b1; wb_tag = 5'd4; wb_data = 32'h999;
        @(posedge clk); #1;
        flush = 1'b0; alloc_req = 1'b0; wb_valid = 1'b0;
        sbq.delete();
        tb_tail = '0;
        rd_tag_a = 5'd6; rd_tag_b = 5'd4;
        #1;
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_count_zero", 64'(count), 64'd0);
        chk("t6_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("t6_cm0", 64'(cm0_valid), 64'd0);
        chk("t6_rd_a", 64'(rd_ready_a), 64'd0);
        chk("t6_rd_b", 64'(rd_ready_b), 64'd0);
        idle(2);

        // Reset mid-stream while a retirement is pending
        do_alloc(5'd2, 32'h44);
        do_alloc(5'd3, 32'h55);
        wb(5'd0, 32'h44);
        chk("rst_pending_cm0", 64'(cm0_valid), 64'd1);
        rst = 1'b0;
        sbq.delete();
        tb_tail = '0;
        #1;
        chk("rst2_count", 64'(count), 64'd0);
        chk("rst2_empty", 64'(empty), 64'd1);
        chk("rst2_full", 64'(full), 64'd0);
        chk("rst2_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst2_cm0", 64'(cm0_valid), 64'd0);
        chk("rst2_alloc_tag", 64'(alloc_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        do_alloc(5'd7, 32'h77);
        wb(5'd0, 32'h77);
        idle(2);
        chk("final_queue", 64'(sbq.size()), 64'd0);
        chk("final_empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
